// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer helpers for async_fifo
// Purpose: pointer type, Gray-code conversions and address-width helper.
// Ports: none (package).
package async_fifo_pkg;

  // Wide enough for any practical pointer; callers zero-extend and
  // truncate, which leaves the Gray relation intact.
  typedef logic [31:0] ptr_t;

  localparam int DEFAULT_SIZE = 16;

  function automatic int addr_bits(input int size);
    return $clog2(size);
  endfunction

  localparam int DEFAULT_ADDR = addr_bits(DEFAULT_SIZE);

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Used for debug and level calculations; not on the flag path.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/async_fifo_sync.sv
// rtl/async_fifo_sync.sv - two-flop pointer synchronizer
// Purpose: carries a Gray pointer across to the opposite port.
// Ports: clk, rstn (async active-low), d (WIDTH in), q (WIDTH out, 2 flops late).
module async_fifo_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - Gray-pointer FIFO with synchronized full/empty flags
// Purpose: rate-decoupling buffer, BITS wide and SIZE deep, built with the
//   dual-clock pointer architecture on a single clock.
// Ports: clk, rstn (async active-low); p_write_en/p_write_data/p_write_full
//   write port; p_read_en/p_read_data (registered)/p_read_empty read port.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty
);

  localparam int ADDR = addr_bits(SIZE);
  // Full when the write Gray pointer equals the synced read pointer with
  // its top two bits inverted (one lap ahead in Gray space).
  localparam logic [ADDR:0] FULL_MASK = (ADDR + 1)'(3) << (ADDR - 1);

  logic [BITS-1:0] mem [SIZE];

  logic [ADDR:0] wbin, wgray, wbin_next;
  logic [ADDR:0] rbin, rgray, rbin_next;
  logic [ADDR:0] wgray_sync2, rgray_sync2;
  logic          wr_ok, rd_ok;

  assign wr_ok     = p_write_en && !p_write_full;
  assign rd_ok     = p_read_en && !p_read_empty;
  assign wbin_next = wbin + (ADDR + 1)'(1);
  assign rbin_next = rbin + (ADDR + 1)'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin  <= '0;
      wgray <= '0;
    end else if (wr_ok) begin
      wbin  <= wbin_next;
      wgray <= (ADDR + 1)'(bin2gray(ptr_t'(wbin_next)));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wbin[ADDR-1:0]] <= p_write_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rbin        <= '0;
      rgray       <= '0;
      p_read_data <= '0;
    end else if (rd_ok) begin
      rbin        <= rbin_next;
      rgray       <= (ADDR + 1)'(bin2gray(ptr_t'(rbin_next)));
      p_read_data <= mem[rbin[ADDR-1:0]];
    end
  end

  async_fifo_sync #(.WIDTH(ADDR + 1)) u_sync_w2r (
    .clk  (clk),
    .rstn (rstn),
    .d    (wgray),
    .q    (wgray_sync2)
  );

  async_fifo_sync #(.WIDTH(ADDR + 1)) u_sync_r2w (
    .clk  (clk),
    .rstn (rstn),
    .d    (rgray),
    .q    (rgray_sync2)
  );

  // Each flag compares a local pointer with a delayed copy of the other
  // side, so both are pessimistic by the synchronizer latency.
  assign p_read_empty = (rgray == wgray_sync2);
  assign p_write_full = (wgray == (rgray_sync2 ^ FULL_MASK));

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - self-checking bench for async_fifo
module tb_async_fifo;

  localparam int BITS = 32;
  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            p_write_en = 1'b0;
  logic [BITS-1:0] p_write_data = '0;
  logic            p_write_full;
  logic            p_read_en = 1'b0;
  logic [BITS-1:0] p_read_data;
  logic            p_read_empty;

  async_fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .p_write_en   (p_write_en),
    .p_write_data (p_write_data),
    .p_write_full (p_write_full),
    .p_read_en    (p_read_en),
    .p_read_data  (p_read_data),
    .p_read_empty (p_read_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a data queue plus transfer totals. Each side only
  // sees the other side's total as it stood two edges earlier.
  logic [BITS-1:0] q[$];
  logic [BITS-1:0] exp_rdata;
  int wr_total, rd_total, wr_d1, wr_d2, rd_d1, rd_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_empty();
    return rd_total == wr_d2;
  endfunction

  function automatic logic exp_full();
    return (wr_total - rd_d2) == SIZE;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_rdata = '0;
    wr_total = 0; rd_total = 0;
    wr_d1 = 0; wr_d2 = 0; rd_d1 = 0; rd_d2 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_empty"}, 32'(p_read_empty), 32'(exp_empty()));
    check({tag, "_full"},  32'(p_write_full), 32'(exp_full()));
    check({tag, "_rdata"}, p_read_data, exp_rdata);
  endtask

  // One clock: drive at posedge+1, model the edge, compare at posedge+1.
  task automatic cycle(input logic we, input logic [BITS-1:0] wd, input logic re,
                       input string tag);
    logic wa, ra;
    p_write_en   = we;
    p_write_data = wd;
    p_read_en    = re;
    wa = we && !exp_full();
    ra = re && !exp_empty();
    @(posedge clk);
    #1;
    wr_d2 = wr_d1; wr_d1 = wr_total;
    rd_d2 = rd_d1; rd_d1 = rd_total;
    if (ra) begin
      exp_rdata = q.pop_front();
      rd_total++;
    end
    if (wa) begin
      q.push_back(wd);
      wr_total++;
    end
    check_outputs(tag);
  endtask

  initial begin
    int start_rd, budget;
    logic [31:0] seed_dummy;

    model_reset();
    // Reset held for 5 clocks.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_outputs("reset");
    end
    rstn = 1'b1;
    check_outputs("post_reset");

    // Smoke: 16 writes, 2 idle, 16 reads.
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0, "smoke_wr");
    cycle(1'b0, '0, 1'b0, "smoke_idle");
    cycle(1'b0, '0, 1'b0, "smoke_idle");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1, "smoke_rd");
      check("smoke_seq", p_read_data, 32'(i));
    end
    check("smoke_empty_end", 32'(p_read_empty), 32'd1);

    // Full: 17 writes, the last one must be dropped.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 32'(100 + i), 1'b0, "full_wr");
      if (i == 15) check("full_at16", 32'(p_write_full), 32'd1);
    end
    check("full_drop", 32'(q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1, "full_rd");
      check("full_seq", p_read_data, 32'(100 + i));
    end
    check("full_empty_end", 32'(p_read_empty), 32'd1);

    // Flag latency of a single write into an empty FIFO.
    cycle(1'b0, '0, 1'b0, "lat_idle");
    cycle(1'b0, '0, 1'b0, "lat_idle");
    cycle(1'b1, 32'h0000_0777, 1'b0, "lat_wr");
    check("lat_n", 32'(p_read_empty), 32'd1);
    cycle(1'b0, '0, 1'b0, "lat_n1");
    check("lat_n1_empty", 32'(p_read_empty), 32'd1);
    cycle(1'b0, '0, 1'b0, "lat_n2");
    check("lat_n2_empty", 32'(p_read_empty), 32'd0);
    cycle(1'b0, '0, 1'b1, "lat_rd");
    check("lat_data", p_read_data, 32'h0000_0777);

    // Randomized interleaving until 100 reads complete.
    seed_dummy = $urandom(7);
    start_rd = rd_total;
    budget = 0;
    while ((rd_total - start_rd) < 100 && budget < 3000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), "rand");
      budget++;
    end
    check("rand_done", 32'((rd_total - start_rd) >= 100), 32'd1);
    check("rand_wrap", 32'(wr_total > 4 * 2 * SIZE), 32'd1);

    // Mid-operation reset between edges.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(200 + i), 1'b0, "mid_wr");
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_reset");
    check("mid_reset_empty", 32'(p_read_empty), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_outputs("mid_release");
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0, "mid_wr2");
    cycle(1'b0, '0, 1'b0, "mid_idle");
    cycle(1'b0, '0, 1'b0, "mid_idle");
    cycle(1'b0, '0, 1'b1, "mid_rd");
    check("mid_data", p_read_data, 32'hA5A5_A5A5);
    cycle(1'b0, '0, 1'b0, "mid_hold");
    check("mid_hold_data", p_read_data, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Circular-buffer FIFO, BITS wide and SIZE deep, with a write port and a read port.
- Uses the dual-clock FIFO architecture: binary/Gray pointers, two-flop pointer synchronizers and conservative full/empty flags.
- Both ports are clocked by a single clock, so the block can later be split into true dual-clock domains without changing its interface or flag semantics.
- Sits between a producer and a consumer as a rate-decoupling buffer.

Parameters:
- BITS, 32, width of each entry in bits.
- SIZE, 16, number of entries; must be a power of two and at least 2. ADDR = $clog2(SIZE).

Ports:
- clk  input  1  single clock for both ports; all state updates on the rising edge.
- rstn  input  1  reset; asynchronous assert, active-low; deassertion is synchronous to clk.
- p_write_en  input  1  write request; one entry per cycle when accepted.
- p_write_data  input  BITS  data to write.
- p_write_full  output  1  FIFO full; writes are ignored while 1.
- p_read_en  input  1  read request; one entry per cycle when accepted.
- p_read_data  output  BITS  registered read data.
- p_read_empty  output  1  FIFO empty; reads are ignored while 1.

Behaviour:
- Reset (rstn=0), takes effect immediately without waiting for a clock edge:
  - write and read pointers (binary and Gray, ADDR+1 bits) = 0;
  - both synchronizer chains = 0;
  - p_write_full=0, p_read_empty=1, p_read_data=0;
  - memory contents are not reset.
- Write accepted (wr_ok) = p_write_en && !p_write_full, sampled at a rising clk edge.
  - On wr_ok: mem[wptr[ADDR-1:0]] <= p_write_data; wptr increments.
  - Write while full is dropped: no state change, no error flag.
- Read accepted (rd_ok) = p_read_en && !p_read_empty.
  - On rd_ok: p_read_data <= mem[rptr[ADDR-1:0]]; rptr increments.
  - The data is valid after the same edge (1-cycle latency).
  - p_read_data holds its value when no read is accepted.
- Pointers are ADDR+1 bits and wrap modulo 2*SIZE; the extra MSB distinguishes full from empty. Gray code = bin ^ (bin>>1), registered alongside the binary pointer.
- Synchronizers: the write-side Gray pointer passes through a 2-flop chain toward the read side; the read-side Gray pointer passes through a 2-flop chain toward the write side.
- Empty flag: p_read_empty = (rptr_gray == wptr_gray_sync2).
  - It asserts right after the edge that reads the last entry.
  - It deasserts on the 2nd edge after the edge that accepted the first write.
- Full flag: p_write_full = (wptr_gray == {~rptr_gray_sync2[ADDR:ADDR-1], rptr_gray_sync2[ADDR-2:0]}).
  - It asserts right after the edge that writes entry number SIZE.
  - It deasserts on the 2nd edge after a read frees a slot.
- Both flags are pessimistic; they are never optimistic, so no overflow or underflow is possible.
- Simultaneous wr_ok and rd_ok are both performed on the same edge. When the FIFO is full, a simultaneous write is dropped and only the read is performed; likewise for read-when-empty.
- Data order is strict FIFO, including across pointer wrap-around (more than SIZE total transfers).
- Reset mid-operation: all queued data is discarded and the flags return to their reset values immediately.

Decomposition:
- Package async_fifo_pkg:
  - function bin2gray(logic [ADDR:0]) and gray2bin (for debug/level use);
  - a localparam helper for ADDR computation.
- Sub-module async_fifo_sync: 2-flop synchronizer, parameter WIDTH, asynchronous active-low reset to 0. It is instantiated twice, once per pointer direction.
- Memory is an unreset register array inside async_fifo.

Test Plan:
- Reset: hold rstn=0 for 5 clks, then release. Require p_read_empty=1, p_write_full=0, p_read_data=0 during and after reset.
- Smoke: write 0..15 on 16 consecutive cycles, then wait 2 clks and read 16. Require the read data sequence 0..15 exactly, and p_read_empty=1 after the 16th read.
- Full: write 17 values (100..116) without reading. Require p_write_full=1 after the 16th write and the 17th write dropped. Reading 16 must return 100..115, then the FIFO is empty.
- Flag latency: with the FIFO empty, do a single write at edge N. Require p_read_empty to stay 1 through edge N+1 and fall after edge N+2.
- Interleaved/wrap: run 100 transfers with randomized p_write_en/p_read_en (SEED=7), honouring the flags. The scoreboard must report all data in order, no loss and no duplicates, with pointers wrapping more than 3 times.
- Mid-op reset: write 5 entries, then pulse rstn low between edges. Require p_read_empty=1 immediately, and the next write/read of 0xA5A5A5A5 to return 0xA5A5A5A5.
